data_memory_responder: RTL and testbench

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder.sv | 183 ++++++++++++++++++
 tb/tb_data_memory_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder
//   RV32I data-memory responder with a fixed response latency. It takes one
//   load/store request at a time and answers after WAIT_STATES extra cycles.
//   Stores are byte-lane masked. Loads are sign- or zero-extended. Misaligned
//   accesses, out-of-range accesses and illegal width codes return resp_error
//   and have no effect on storage.
//
// Ports
//   clk, rst          clock and asynchronous active-high reset
//   req_valid/ready   request handshake (req_ready is high only in IDLE)
//   req_write         1 = store, 0 = load
//   req_funct3        RV32I width code (B, H, W, BU, HU)
//   req_address       byte address
//   req_write_data    store data, right-aligned
//   resp_valid/ready  response handshake (resp_valid is high only in RESP)
//   resp_read_data    extended load data; 0 for stores and for errors
//   resp_error        access fault for this transaction
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_read_data,
  output logic        resp_error
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  count;
  logic        lat_write;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_address;
  logic [31:0] lat_write_data;

  logic [31:0] mem [DEPTH_WORDS];

  // When WAIT_STATES is 0, RESP is entered on the acceptance edge itself,
  // before the latches hold anything. The live request inputs are therefore
  // used in IDLE, and the latched copy is used everywhere else.
  logic        txn_write;
  logic [2:0]  txn_funct3;
  logic [31:0] txn_address;
  logic [31:0] txn_write_data;
  logic        txn_error;
  logic        enter_resp;
  logic [IDX_W-1:0] txn_index;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic [31:0] wr_data;
  logic [3:0]  wr_lanes;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = (WAIT_STATES == 0) ? RESP : WAIT;
      end
      WAIT: if (count == 4'd1) state_next = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign enter_resp = (state_next == RESP) && (state != RESP);

  always_comb begin
    txn_write      = (state == IDLE) ? req_write      : lat_write;
    txn_funct3     = (state == IDLE) ? req_funct3     : lat_funct3;
    txn_address    = (state == IDLE) ? req_address    : lat_address;
    txn_write_data = (state == IDLE) ? req_write_data : lat_write_data;
    txn_index      = txn_address[IDX_W+1:2];

    txn_error = ({2'b00, txn_address[31:2]} >= DEPTH_W32);
    unique case (txn_funct3)
      3'b000, 3'b100: txn_error = txn_error | (txn_write & txn_funct3[2]);
      3'b001, 3'b101: txn_error = txn_error | txn_address[0] | (txn_write & txn_funct3[2]);
      3'b010:         txn_error = txn_error | (txn_address[1:0] != 2'b00);
      default:        txn_error = 1'b1;
    endcase
  end

  // Load path: pick the lane, then sign-extend or zero-extend it.
  always_comb begin
    rd_word = mem[txn_index];
    unique case (txn_address[1:0])
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = txn_address[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (txn_funct3)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_data = {24'h0, rd_byte};
      3'b101:  load_data = {16'h0, rd_half};
      default: load_data = rd_word;
    endcase
  end

  // Store path: replicate the data across the word and enable only the
  // addressed lanes.
  always_comb begin
    wr_data  = txn_write_data;
    wr_lanes = 4'b1111;
    unique case (txn_funct3[1:0])
      2'b00: begin
        wr_data  = {4{txn_write_data[7:0]}};
        wr_lanes = 4'b0001 << txn_address[1:0];
      end
      2'b01: begin
        wr_data  = {2{txn_write_data[15:0]}};
        wr_lanes = txn_address[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every flop samples values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      count          <= 4'd0;
      lat_write      <= 1'b0;
      lat_funct3     <= 3'b000;
      lat_address    <= 32'h0;
      lat_write_data <= 32'h0;
      resp_read_data <= 32'h0;
      resp_error     <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        lat_write      <= req_write;
        lat_funct3     <= req_funct3;
        lat_address    <= req_address;
        lat_write_data <= req_write_data;
        count          <= WAIT_INIT;
      end else if (state == WAIT) begin
        count <= count - 4'd1;
      end
      if (enter_resp) begin
        resp_error     <= txn_error;
        resp_read_data <= (txn_error || txn_write) ? 32'h0 : load_data;
      end
    end
  end

  // NOTE: the storage array has no reset. Its contents survive rst, and
  // leaving it unreset lets it map onto RAM. Writes are still blocked while
  // rst is high so that an abandoned store cannot commit.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && txn_write && !txn_error) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_lanes[i]) mem[txn_index][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder. It drives one instance with
// WAIT_STATES = 2 and DEPTH_WORDS = 1024, and a second with WAIT_STATES = 0
// and DEPTH_WORDS = 16. Both instances share the request fields, and each has
// its own req_valid.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rv2 = 1'b0;
  logic        rv0 = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b010;
  logic [31:0] req_address = 32'h0;
  logic [31:0] req_write_data = 32'h0;
  logic        resp_ready = 1'b1;

  logic        req_ready2, resp_valid2, resp_error2;
  logic [31:0] resp_read_data2;
  logic        req_ready0, resp_valid0, resp_error0;
  logic [31:0] resp_read_data0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(req_ready2),
    .req_write(req_write), .req_funct3(req_funct3), .req_address(req_address),
    .req_write_data(req_write_data), .resp_valid(resp_valid2),
    .resp_ready(resp_ready), .resp_read_data(resp_read_data2),
    .resp_error(resp_error2)
  );

  data_memory_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(req_ready0),
    .req_write(req_write), .req_funct3(req_funct3), .req_address(req_address),
    .req_write_data(req_write_data), .resp_valid(resp_valid0),
    .resp_ready(resp_ready), .resp_read_data(resp_read_data0),
    .resp_error(resp_error0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction with resp_ready = 1. The request fields are
  // scrambled after acceptance, and the transaction in flight must not see it.
  task automatic txn(input bit which, input string tag, input logic wr,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    int cyc;
    int exp_cyc;
    logic [31:0] rd;
    logic err;
    exp_cyc = which ? 1 : 3;
    @(negedge clk);
    req_write = wr; req_funct3 = f3; req_address = a; req_write_data = wd;
    if (which) rv0 = 1'b1; else rv2 = 1'b1;
    @(posedge clk); #1;
    rv0 = 1'b0; rv2 = 1'b0;
    req_write = ~wr; req_funct3 = 3'b010; req_address = a ^ 32'h4; req_write_data = ~wd;
    cyc = 1;
    while (!(which ? resp_valid0 : resp_valid2) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    rd  = which ? resp_read_data0 : resp_read_data2;
    err = which ? resp_error0 : resp_error2;
    check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " data"}, rd, exp_rd);
    check({tag, " error"}, {31'h0, err}, {31'h0, exp_err});
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    logic [31:0] held;

    // Reset behaviour.
    repeat (2) @(posedge clk);
    #1 check("in reset resp_valid", {31'h0, resp_valid2}, 32'h0);
    @(negedge clk) rst = 1'b0;
    #1;
    check("reset req_ready", {31'h0, req_ready2}, 32'h1);
    check("reset resp_valid", {31'h0, resp_valid2}, 32'h0);
    check("reset resp_read_data", resp_read_data2, 32'h0);
    check("reset resp_error", {31'h0, resp_error2}, 32'h0);

    // Word store, then word load.
    txn(0, "SW 0x10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    txn(0, "LW 0x10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte lanes and extension.
    txn(0, "SW0 0x10", 1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0);
    txn(0, "SB 0x11", 1'b1, 3'b000, 32'h11, 32'h12345680, 32'h0, 1'b0);
    txn(0, "LB 0x11", 1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0);
    txn(0, "LBU 0x11", 1'b0, 3'b100, 32'h11, 32'h0, 32'h00000080, 1'b0);
    txn(0, "LW after SB", 1'b0, 3'b010, 32'h10, 32'h0, 32'h00008000, 1'b0);
    txn(0, "SH 0x16", 1'b1, 3'b001, 32'h16, 32'hABCD8001, 32'h0, 1'b0);
    txn(0, "LH 0x16", 1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF8001, 1'b0);
    txn(0, "LHU 0x16", 1'b0, 3'b101, 32'h16, 32'h0, 32'h00008001, 1'b0);

    // Faults leave storage untouched.
    txn(0, "LH 0x13 misaligned", 1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1);
    txn(0, "SW 0x12 misaligned", 1'b1, 3'b010, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn(0, "LW out of range", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
    txn(0, "SB out of range", 1'b1, 3'b000, 32'h1000, 32'hFF, 32'h0, 1'b1);
    txn(0, "store funct3 100", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn(0, "load funct3 011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    txn(0, "LW after faults", 1'b0, 3'b010, 32'h10, 32'h0, 32'h00008000, 1'b0);

    // Backpressure: resp_ready low for 5 cycles while in RESP.
    @(negedge clk);
    req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h10; rv2 = 1'b1;
    @(posedge clk); #1;
    rv2 = 1'b0; resp_ready = 1'b0;
    acc = 0;
    while (!resp_valid2 && acc < 20) begin
      @(posedge clk); #1;
      acc++;
    end
    held = resp_read_data2;
    check("bp first data", held, 32'h00008000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp resp_valid held", {31'h0, resp_valid2}, 32'h1);
      check("bp data held", resp_read_data2, 32'h00008000);
      check("bp req_ready low", {31'h0, req_ready2}, 32'h0);
    end
    @(negedge clk) resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp after handshake resp_valid", {31'h0, resp_valid2}, 32'h0);
    check("bp after handshake req_ready", {31'h0, req_ready2}, 32'h1);

    // A reset during WAIT abandons the store.
    txn(0, "SW 0x20 prior", 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
    txn(0, "LW 0x20 prior", 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    req_write = 1'b1; req_funct3 = 3'b010; req_address = 32'h20;
    req_write_data = 32'h12345678; rv2 = 1'b1;
    @(posedge clk); #1;
    rv2 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid-wait rst resp_valid", {31'h0, resp_valid2}, 32'h0);
    check("mid-wait rst resp_read_data", resp_read_data2, 32'h0);
    check("mid-wait rst resp_error", {31'h0, resp_error2}, 32'h0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 check("after rst req_ready", {31'h0, req_ready2}, 32'h1);
    txn(0, "LW 0x20 after rst", 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

    // WAIT_STATES = 0 instance.
    txn(1, "WS0 SW 0x8", 1'b1, 3'b010, 32'h8, 32'h0BADF00D, 32'h0, 1'b0);
    txn(1, "WS0 LW 0x8", 1'b0, 3'b010, 32'h8, 32'h0, 32'h0BADF00D, 1'b0);
    txn(1, "WS0 LW out of range", 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b1);

    // With req_valid held high, one request is accepted every two cycles.
    @(negedge clk);
    req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h8; rv0 = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (req_ready0) acc++;
      @(posedge clk); #1;
      check("WS0 stream resp_valid", {31'h0, resp_valid0}, (i % 2 == 0) ? 32'h1 : 32'h0);
      if (i % 2 == 0) check("WS0 stream data", resp_read_data0, 32'h0BADF00D);
      @(negedge clk);
    end
    rv0 = 1'b0;
    check("WS0 stream accept count", 32'(acc), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
